aes_sched: RTL and testbench
============================

AES_SCHED -- requirements
Module: aes_sched

Interface
REQ-001 Parameter: TIMEOUT, 15, watchdog limit in cycles from issue pulse to core result; legal 12..255.
REQ-002 Parameter: FIXED_PRIO, 0, 0 = round-robin between ports A/B; 1 = port A always wins.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 nreset  in  1  asynchronous, active-low reset.
REQ-005 a_v_i / b_v_i  in  1  requester A/B has a job.
REQ-006 a_rdy_o / b_rdy_o  out  1  job accepted on cycle where v_i & rdy_o.
REQ-007 a_data_i / b_data_i  in  128  plaintext block; a_key_i / b_key_i  in  128  cipher key.
REQ-008 core_data_v_o  out  1  one-cycle start pulse to the AES core.
REQ-009 core_data_o / core_key_o  out  128  block/key to the core; valid with core_data_v_o.
REQ-010 core_res_v_i  in  1  core result valid pulse; core_res_i  in  128  core result.
REQ-011 a_res_v_o / b_res_v_o  out  1  result held for requester A/B.
REQ-012 a_res_o / b_res_o  out  128  result data; a_res_rdy_i / b_res_rdy_i  in  1  result consumed.
REQ-013 busy_o  out  1  high in any state other than IDLE; err_o  out  1  sticky protocol/timeout error.

Function
REQ-014 FSM states: IDLE, ISSUE, WAIT; exactly one job in flight at the core at any time.
REQ-015 Port X is eligible when X_v_i=1 and X_res_v_o=0 (result slot empty).
REQ-016 rdy_o is asserted only in IDLE, for at most one eligible port per cycle (the grant); the other port's rdy_o is 0.
REQ-017 Round-robin: if both are eligible, grant the port not granted last; reset value of the last-grant register = B, so A wins the first contention.
REQ-018 A single eligible port is granted regardless of last-grant; FIXED_PRIO=1 always grants A when A is eligible.
REQ-019 On accept (cycle N): latch data, key and owner (A/B); IDLE->ISSUE; update last-grant.
REQ-020 ISSUE (cycle N+1): core_data_v_o=1 with the latched data/key; ISSUE->WAIT; clear the watchdog counter (8-bit).
REQ-021 In all other cycles core_data_v_o=0; core_data_o/core_key_o keep the latched values.
REQ-022 WAIT: the counter increments each cycle; on core_res_v_i=1, capture core_res_i into the owner's result register, set owner res_v_o, WAIT->IDLE.
REQ-023 With an 11-cycle core latency, core_res_v_i arrives at N+12 and owner res_v_o=1 from N+13.
REQ-024 res_v_o stays high and res_o stays stable until the cycle where res_v_o & res_rdy_i; res_v_o clears the next edge.
REQ-025 A port's result-slot clear and that port's new accept may occur in the same cycle only if res_v_o is already 0; no accept while the slot is full.
REQ-026 Timeout: if the counter reaches TIMEOUT in WAIT with no result, set err_o, leave the owner slot empty, go WAIT->IDLE.
REQ-027 core_res_v_i in IDLE or ISSUE is stray: ignore the data and set err_o.
REQ-028 core_res_v_i on the same cycle as timeout: the result wins; it is captured and err_o is not set.
REQ-029 err_o stays set until reset; it does not block operation.
REQ-030 busy_o=1 in ISSUE and WAIT.

Reset
REQ-031 nreset low asynchronously forces: state IDLE, all rdy_o=0, core_data_v_o=0, res_v_o=0, err_o=0, busy_o=0, last-grant=B, counter=0, data/key/result registers=0.
REQ-032 A reset mid-WAIT drops the job silently; a core result arriving after reset release counts as stray (REQ-027).

Verification
REQ-033 FIPS-197 vector on A: data 00112233445566778899aabbccddeeff, key 000102030405060708090a0b0c0d0e0f -> core_data_v_o at N+1, a_res_o 69c4e0d86a7b0430d8cdb78070b4c55a, a_res_v_o from N+13.
REQ-034 A and B valid together from reset -> A granted first, B accepted in the first IDLE after A's result, then A again if still pending.
REQ-035 A result not consumed (a_res_rdy_i=0) with A re-requesting -> a_rdy_o stays 0 and B is served; A is accepted the cycle after the handshake.
REQ-036 Core model withholds the result -> err_o=1 exactly TIMEOUT cycles after the issue pulse, a_res_v_o stays 0, busy_o falls and the next request is accepted.
REQ-037 core_res_v_i pulsed in IDLE -> err_o=1 and no res_v_o change; nreset pulsed mid-WAIT -> all outputs at reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/aes_sched.sv
// Two-port scheduler for a single AES core: arbitrates A/B jobs, issues one job at a time, routes the result back.
// Latency: start pulse one cycle after accept; result visible one cycle after core_res_v_i. Backpressure: a port is
// not granted while its result slot is full; a watchdog abandons jobs the core never answers.
module aes_sched #(
    parameter int TIMEOUT    = 15,
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic         clk,
    input  logic         nreset,
    input  logic         a_v_i,
    output logic         a_rdy_o,
    input  logic [127:0] a_data_i,
    input  logic [127:0] a_key_i,
    input  logic         b_v_i,
    output logic         b_rdy_o,
    input  logic [127:0] b_data_i,
    input  logic [127:0] b_key_i,
    output logic         core_data_v_o,
    output logic [127:0] core_data_o,
    output logic [127:0] core_key_o,
    input  logic         core_res_v_i,
    input  logic [127:0] core_res_i,
    output logic         a_res_v_o,
    output logic [127:0] a_res_o,
    input  logic         a_res_rdy_i,
    output logic         b_res_v_o,
    output logic [127:0] b_res_o,
    input  logic         b_res_rdy_i,
    output logic         busy_o,
    output logic         err_o
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_t     state;
    logic       last_b;
    logic       owner_b;
    logic [7:0] wd_cnt;

    logic a_elig, b_elig, grant_a, grant_b, in_idle;

    always_comb begin
        a_elig  = a_v_i & ~a_res_v_o;
        b_elig  = b_v_i & ~b_res_v_o;
        grant_a = a_elig & (FIXED_PRIO | ~b_elig | last_b);
        grant_b = b_elig & ~grant_a;
        // Grants are held off while reset is asserted so no handshake can be seen during reset.
        in_idle = nreset & (state == IDLE);
        a_rdy_o = in_idle & grant_a;
        b_rdy_o = in_idle & grant_b;
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state         <= IDLE;
            last_b        <= 1'b1;
            owner_b       <= 1'b0;
            wd_cnt        <= 8'd0;
            core_data_v_o <= 1'b0;
            core_data_o   <= 128'd0;
            core_key_o    <= 128'd0;
            a_res_v_o     <= 1'b0;
            a_res_o       <= 128'd0;
            b_res_v_o     <= 1'b0;
            b_res_o       <= 128'd0;
            busy_o        <= 1'b0;
            err_o         <= 1'b0;
        end else begin
            core_data_v_o <= 1'b0;
            if (a_res_v_o && a_res_rdy_i) a_res_v_o <= 1'b0;
            if (b_res_v_o && b_res_rdy_i) b_res_v_o <= 1'b0;

            case (state)
                IDLE: begin
                    if (core_res_v_i) err_o <= 1'b1;
                    if (a_rdy_o || b_rdy_o) begin
                        core_data_o   <= b_rdy_o ? b_data_i : a_data_i;
                        core_key_o    <= b_rdy_o ? b_key_i  : a_key_i;
                        owner_b       <= b_rdy_o;
                        last_b        <= b_rdy_o;
                        core_data_v_o <= 1'b1;
                        busy_o        <= 1'b1;
                        state         <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (core_res_v_i) err_o <= 1'b1;
                    // The issue cycle itself counts toward the watchdog.
                    wd_cnt <= 8'd1;
                    state  <= WAIT;
                end
                WAIT: begin
                    wd_cnt <= wd_cnt + 8'd1;
                    if (core_res_v_i) begin
                        if (owner_b) begin
                            b_res_o   <= core_res_i;
                            b_res_v_o <= 1'b1;
                        end else begin
                            a_res_o   <= core_res_i;
                            a_res_v_o <= 1'b1;
                        end
                        busy_o <= 1'b0;
                        state  <= IDLE;
                    end else if (wd_cnt == TO_LAST) begin
                        err_o  <= 1'b1;
                        busy_o <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: begin
                    busy_o <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_sched.sv
// Scoreboard bench for aes_sched: behavioural AES core stand-in, per-port expected-result queues, timing checks.
module tb_aes_sched;

    localparam int TO = 15;
    localparam logic [127:0] FIPS_D = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_K = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIPS_C = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic         clk = 1'b0;
    logic         nreset;
    logic         a_v_i, b_v_i, a_rdy_o, b_rdy_o;
    logic [127:0] a_data_i, a_key_i, b_data_i, b_key_i;
    logic         core_data_v_o;
    logic [127:0] core_data_o, core_key_o;
    logic         core_res_v_i;
    logic [127:0] core_res_i;
    logic         a_res_v_o, b_res_v_o, a_res_rdy_i, b_res_rdy_i;
    logic [127:0] a_res_o, b_res_o;
    logic         busy_o, err_o;

    always #5 clk = ~clk;

    aes_sched #(.TIMEOUT(TO), .FIXED_PRIO(1'b0)) dut (
        .clk(clk), .nreset(nreset),
        .a_v_i(a_v_i), .a_rdy_o(a_rdy_o), .a_data_i(a_data_i), .a_key_i(a_key_i),
        .b_v_i(b_v_i), .b_rdy_o(b_rdy_o), .b_data_i(b_data_i), .b_key_i(b_key_i),
        .core_data_v_o(core_data_v_o), .core_data_o(core_data_o), .core_key_o(core_key_o),
        .core_res_v_i(core_res_v_i), .core_res_i(core_res_i),
        .a_res_v_o(a_res_v_o), .a_res_o(a_res_o), .a_res_rdy_i(a_res_rdy_i),
        .b_res_v_o(b_res_v_o), .b_res_o(b_res_o), .b_res_rdy_i(b_res_rdy_i),
        .busy_o(busy_o), .err_o(err_o)
    );

    typedef struct packed {
        logic [127:0] d;
        logic [127:0] k;
    } job_t;

    job_t         a_jobs[$], b_jobs[$];
    logic [127:0] a_exp[$], b_exp[$];
    int           acc_port[$], acc_cyc[$];
    int           n_tests = 0, n_fail = 0;
    int           cyc = 0, core_lat = 11, core_cnt = 0, rdy_viol = 0;
    int           issue_cyc, a_rise_cyc, err_cyc, a_hs_cyc;
    bit           a_take = 1, b_take = 1, withhold = 0, core_pend = 0;
    logic         prev_a_resv, prev_err;
    logic [127:0] core_val, last_issue_data;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Stand-in for the AES core: exact for the FIPS-197 vector, an arbitrary mix otherwise.
    function automatic logic [127:0] fake_aes(input logic [127:0] d, input logic [127:0] k);
        if (d == FIPS_D && k == FIPS_K) return FIPS_C;
        return d ^ {k[63:0], k[127:64]} ^ 128'h5a5a_0f0f_c3c3_9696_1234_5678_9abc_def0;
    endfunction

    function automatic job_t mk_job(input int seed);
        job_t j;
        j.d = {$urandom(), $urandom(), $urandom(), 32'(seed)};
        j.k = {$urandom(), $urandom(), 32'(seed), $urandom()};
        return j;
    endfunction

    task automatic cycle();
        @(negedge clk);
        if ((a_rdy_o && a_res_v_o) || (b_rdy_o && b_res_v_o) || (a_rdy_o && b_rdy_o)) rdy_viol++;
        if (a_v_i && a_rdy_o) begin
            acc_port.push_back(0);
            acc_cyc.push_back(cyc);
            if (!withhold) a_exp.push_back(fake_aes(a_data_i, a_key_i));
            void'(a_jobs.pop_front());
        end
        if (b_v_i && b_rdy_o) begin
            acc_port.push_back(1);
            acc_cyc.push_back(cyc);
            if (!withhold) b_exp.push_back(fake_aes(b_data_i, b_key_i));
            void'(b_jobs.pop_front());
        end
        if (core_data_v_o) begin
            issue_cyc       = cyc;
            last_issue_data = core_data_o;
            if (!withhold) begin
                core_pend = 1;
                core_cnt  = core_lat;
                core_val  = fake_aes(core_data_o, core_key_o);
            end
        end
        if (a_res_v_o && !prev_a_resv) a_rise_cyc = cyc;
        prev_a_resv = a_res_v_o;
        if (a_res_v_o && a_res_rdy_i) begin
            a_hs_cyc = cyc;
            if (a_exp.size() == 0) check("a_res_unexpected", 128'd1, 128'd0);
            else check("a_res", a_res_o, a_exp.pop_front());
        end
        if (b_res_v_o && b_res_rdy_i) begin
            if (b_exp.size() == 0) check("b_res_unexpected", 128'd1, 128'd0);
            else check("b_res", b_res_o, b_exp.pop_front());
        end
        if (err_o && !prev_err) err_cyc = cyc;
        prev_err = err_o;

        @(posedge clk);
        cyc++;
        #1;
        core_res_v_i = 1'b0;
        if (core_pend) begin
            core_cnt--;
            if (core_cnt == 0) begin
                core_res_v_i = 1'b1;
                core_res_i   = core_val;
                core_pend    = 0;
            end
        end
        a_v_i = (a_jobs.size() != 0);
        if (a_v_i) {a_data_i, a_key_i} = {a_jobs[0].d, a_jobs[0].k};
        b_v_i = (b_jobs.size() != 0);
        if (b_v_i) {b_data_i, b_key_i} = {b_jobs[0].d, b_jobs[0].k};
        a_res_rdy_i = a_take;
        b_res_rdy_i = b_take;
    endtask

    task automatic do_reset();
        nreset = 1'b0;
        a_jobs.delete(); b_jobs.delete(); a_exp.delete(); b_exp.delete();
        acc_port.delete(); acc_cyc.delete();
        core_pend = 0; core_res_v_i = 1'b0; a_v_i = 1'b0; b_v_i = 1'b0;
        withhold = 0; core_lat = 11; a_take = 1; b_take = 1;
        a_res_rdy_i = 1'b1; b_res_rdy_i = 1'b1;
        issue_cyc = -1; a_rise_cyc = -1; err_cyc = -1; a_hs_cyc = -1;
        prev_a_resv = 1'b0; prev_err = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        nreset = 1'b1;
    endtask

    function automatic bit quiet();
        return a_jobs.size() == 0 && b_jobs.size() == 0 && a_exp.size() == 0 && b_exp.size() == 0
            && !busy_o && !core_pend;
    endfunction

    task automatic run_quiet(input string tag);
        int i;
        cycle();
        for (i = 0; i < 300 && !quiet(); i++) cycle();
        check(tag, 128'(i < 300), 128'd1);
    endtask

    function automatic int acc_at(input int idx);
        return (acc_cyc.size() > idx) ? acc_cyc[idx] : -1000;
    endfunction

    function automatic int port_at(input int idx);
        return (acc_port.size() > idx) ? acc_port[idx] : 9;
    endfunction

    initial begin
        nreset = 1'b0;
        a_v_i = 1'b1; b_v_i = 1'b1;
        a_data_i = '1; a_key_i = '1; b_data_i = '1; b_key_i = '1;
        a_res_rdy_i = 1'b1; b_res_rdy_i = 1'b1;
        core_res_v_i = 1'b0; core_res_i = '0;
        #12;
        check("rst_rdy", 128'({a_rdy_o, b_rdy_o}), 128'd0);
        check("rst_flags", 128'({core_data_v_o, busy_o, err_o, a_res_v_o, b_res_v_o}), 128'd0);
        check("rst_core_data", core_data_o, 128'd0);
        check("rst_a_res", a_res_o, 128'd0);

        // FIPS-197 vector on A
        do_reset();
        a_jobs.push_back('{FIPS_D, FIPS_K});
        run_quiet("fips_done");
        check("fips_issue_lat", 128'(issue_cyc - acc_at(0)), 128'd1);
        check("fips_issue_data", last_issue_data, FIPS_D);
        check("fips_res_lat", 128'(a_rise_cyc - acc_at(0)), 128'd13);
        check("fips_res_cleared", 128'(a_res_v_o), 128'd0);
        check("fips_no_err", 128'(err_o), 128'd0);

        // Contention from reset: A, then B, then A again
        do_reset();
        a_jobs.push_back(mk_job(1));
        a_jobs.push_back(mk_job(2));
        b_jobs.push_back(mk_job(3));
        run_quiet("rr_done");
        check("rr_order", 128'(port_at(0) * 100 + port_at(1) * 10 + port_at(2)), 128'd10);
        check("rr_b_gap", 128'(acc_at(1) - acc_at(0)), 128'd13);
        check("rr_a_gap", 128'(acc_at(2) - acc_at(1)), 128'd13);

        // A's result slot held full while A re-requests: B is served, A waits for the handshake
        do_reset();
        a_take = 0;
        a_jobs.push_back(mk_job(4));
        a_jobs.push_back(mk_job(5));
        for (int i = 0; i < 100 && a_rise_cyc < 0; i++) cycle();
        b_jobs.push_back(mk_job(6));
        for (int i = 0; i < 100 && !(b_exp.size() == 0 && acc_port.size() == 2 && !busy_o); i++) cycle();
        check("full_b_served", 128'(port_at(1)), 128'd1);
        check("full_a_held", 128'({a_v_i, a_res_v_o, a_rdy_o}), 128'b110);
        a_take = 1;
        for (int i = 0; i < 100 && acc_port.size() < 3; i++) cycle();
        check("full_a_after_hs", 128'(acc_at(2) - a_hs_cyc), 128'd1);
        run_quiet("full_done");

        // Core never answers: watchdog fires, next job still accepted
        do_reset();
        withhold = 1;
        a_jobs.push_back(mk_job(7));
        for (int i = 0; i < 100 && err_cyc < 0; i++) cycle();
        check("to_err_lat", 128'(err_cyc - issue_cyc), 128'(TO));
        check("to_state", 128'({a_res_v_o, busy_o}), 128'd0);
        withhold = 0;
        a_jobs.push_back(mk_job(8));
        run_quiet("to_next_done");
        check("to_next_acc", 128'(acc_port.size()), 128'd2);
        check("to_err_sticky", 128'(err_o), 128'd1);

        // Result lands on the very cycle the watchdog expires: result wins
        do_reset();
        core_lat = TO - 1;
        a_jobs.push_back(mk_job(9));
        run_quiet("edge_done");
        check("edge_res_lat", 128'(a_rise_cyc - issue_cyc), 128'(TO));
        check("edge_no_err", 128'(err_o), 128'd0);

        // Stray core result in IDLE
        do_reset();
        cycle();
        core_res_v_i = 1'b1;
        core_res_i   = {4{$urandom()}};
        cycle();
        cycle();
        check("stray_err", 128'(err_o), 128'd1);
        check("stray_no_res", 128'({a_res_v_o, b_res_v_o}), 128'd0);

        // Reset mid-WAIT: immediate clear, late result becomes stray
        do_reset();
        b_jobs.push_back(mk_job(10));
        repeat (6) cycle();
        check("mw_busy", 128'(busy_o), 128'd1);
        nreset = 1'b0;
        #1;
        check("mw_rst_flags", 128'({busy_o, core_data_v_o, err_o, a_res_v_o, b_res_v_o, a_rdy_o, b_rdy_o}), 128'd0);
        check("mw_rst_core_key", core_key_o, 128'd0);
        b_exp.delete();
        cycle();
        nreset = 1'b1;
        for (int i = 0; i < 30 && core_pend; i++) cycle();
        cycle();
        cycle();
        check("mw_stray_err", 128'(err_o), 128'd1);
        check("mw_no_res", 128'({a_res_v_o, b_res_v_o}), 128'd0);

        check("rdy_protocol", 128'(rdy_viol), 128'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "bench time limit");
    end

endmodule
